// File: rtl/eth_pcs_params.sv
// rtl/eth_pcs_params.sv - shared 64b/66b PCS constants, block-sync defaults and state type
package eth_pcs_params;

    localparam int W_SYNC = 2;
    localparam int W_DATA = 64;

    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

    localparam int SH_CNT_MAX_DFLT   = 64;
    localparam int SH_INVLD_MAX_DFLT = 16;
    localparam int SLIP_WAIT_DFLT    = 2;

    typedef enum logic [1:0] {
        LOCK_INIT    = 2'd0,
        TEST_SH      = 2'd1,
        SLIP_WAIT_ST = 2'd2
    } blk_sync_state_t;

    function automatic logic sh_is_valid(input logic [W_SYNC-1:0] sh);
        return (sh == SYNC_DATA) || (sh == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_pcs_rx_block_sync.sv
// rtl/eth_pcs_rx_block_sync.sv - 64b/66b receive block synchroniser with slip control
module eth_pcs_rx_block_sync
    import eth_pcs_params::*;
#(
    parameter int SH_CNT_MAX   = SH_CNT_MAX_DFLT,
    parameter int SH_INVLD_MAX = SH_INVLD_MAX_DFLT,
    parameter int SLIP_WAIT    = SLIP_WAIT_DFLT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clk_en,
    input  logic              i_grbx_hdr_valid,
    input  logic [W_SYNC-1:0] i_grbx_hdr,
    input  logic [W_DATA-1:0] i_grbx_data,
    output logic              o_grbx_slip,
    output logic              o_block_lock,
    output logic              o_grbx_hdr_valid,
    output logic [W_SYNC-1:0] o_grbx_hdr,
    output logic [W_DATA-1:0] o_grbx_data
);

    localparam logic [6:0] SH_CNT_TERM   = 7'(SH_CNT_MAX);
    localparam logic [4:0] SH_INVLD_TERM = 5'(SH_INVLD_MAX);
    localparam logic [3:0] WAIT_LAST     = 4'(SLIP_WAIT - 1);

    blk_sync_state_t state, state_nxt;
    logic [6:0]      sh_cnt, sh_cnt_nxt, sh_cnt_inc;
    logic [4:0]      sh_invld_cnt, sh_invld_cnt_nxt, sh_invld_cnt_inc;
    logic [3:0]      wait_cnt, wait_cnt_nxt;
    logic            lock_nxt;
    logic            slip_nxt;

    assign sh_cnt_inc       = sh_cnt + 7'd1;
    assign sh_invld_cnt_inc = sh_invld_cnt + 5'd1;

    // One header event resolves the whole valid/invalid/slip decision chain.
    always_comb begin
        state_nxt        = state;
        sh_cnt_nxt       = sh_cnt;
        sh_invld_cnt_nxt = sh_invld_cnt;
        wait_cnt_nxt     = wait_cnt;
        lock_nxt         = o_block_lock;
        slip_nxt         = o_grbx_slip;
        if (i_clk_en) begin
            slip_nxt = 1'b0;
            case (state)
                LOCK_INIT: begin
                    lock_nxt         = 1'b0;
                    sh_cnt_nxt       = '0;
                    sh_invld_cnt_nxt = '0;
                    wait_cnt_nxt     = '0;
                    state_nxt        = TEST_SH;
                end
                TEST_SH: begin
                    if (i_grbx_hdr_valid) begin
                        if (sh_is_valid(i_grbx_hdr)) begin
                            if (sh_cnt_inc == SH_CNT_TERM) begin
                                sh_cnt_nxt       = '0;
                                sh_invld_cnt_nxt = '0;
                                if (sh_invld_cnt == 5'd0) begin
                                    lock_nxt = 1'b1;
                                end
                            end else begin
                                sh_cnt_nxt = sh_cnt_inc;
                            end
                        end else if ((sh_invld_cnt_inc == SH_INVLD_TERM) || !o_block_lock) begin
                            slip_nxt         = 1'b1;
                            lock_nxt         = 1'b0;
                            sh_cnt_nxt       = '0;
                            sh_invld_cnt_nxt = '0;
                            wait_cnt_nxt     = '0;
                            state_nxt        = SLIP_WAIT_ST;
                        end else if (sh_cnt_inc == SH_CNT_TERM) begin
                            sh_cnt_nxt       = '0;
                            sh_invld_cnt_nxt = '0;
                        end else begin
                            sh_cnt_nxt       = sh_cnt_inc;
                            sh_invld_cnt_nxt = sh_invld_cnt_inc;
                        end
                    end
                end
                SLIP_WAIT_ST: begin
                    if (i_grbx_hdr_valid) begin
                        if (wait_cnt == WAIT_LAST) begin
                            wait_cnt_nxt = '0;
                            state_nxt    = TEST_SH;
                        end else begin
                            wait_cnt_nxt = wait_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = LOCK_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= LOCK_INIT;
            sh_cnt       <= '0;
            sh_invld_cnt <= '0;
            wait_cnt     <= '0;
            o_block_lock <= 1'b0;
            o_grbx_slip  <= 1'b0;
        end else begin
            state        <= state_nxt;
            sh_cnt       <= sh_cnt_nxt;
            sh_invld_cnt <= sh_invld_cnt_nxt;
            wait_cnt     <= wait_cnt_nxt;
            o_block_lock <= lock_nxt;
            o_grbx_slip  <= slip_nxt;
        end
    end

    // Header is gated by the lock already held when this block is registered.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_grbx_hdr_valid <= 1'b0;
            o_grbx_hdr       <= '0;
            o_grbx_data      <= '0;
        end else if (i_clk_en) begin
            o_grbx_hdr_valid <= i_grbx_hdr_valid;
            o_grbx_hdr       <= o_block_lock ? i_grbx_hdr : '0;
            o_grbx_data      <= i_grbx_data;
        end
    end

endmodule
